// File: rtl/ro_bus_capture.sv
// Receive side of the time-multiplexed readout bus: decodes the gray-slot owner,
// captures nonzero samples and queues them for a valid/ready consumer. Optional macro: RO_TIMESTAMP_EN.
module ro_bus_capture #(
  parameter int N_CORES = 16,
  parameter int CNT_W   = 19,
  parameter int DEPTH   = 8,
  parameter int CORE_W  = 5
) (
  input  logic                     clk_master,
  input  logic                     rstb,
  input  logic                     en,
  input  logic                     bus_eve,
  input  logic                     bus_pol_eve,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [CORE_W-1:0]        rd_core,
  output logic                     rd_eve,
  output logic                     rd_pol,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
`ifdef RO_TIMESTAMP_EN
  ,
  output logic [CNT_W-1:0]         rd_ts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Owner = index of lowest set bit + 1; zero for the idle slot or cores beyond N_CORES.
  function automatic logic [CORE_W-1:0] owner_of(input logic [CNT_W-1:0] c);
    owner_of = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      if (c[i]) owner_of = (i < N_CORES) ? CORE_W'(i + 1) : '0;
    end
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    sat_inc = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [CNT_W-1:0]  cnt;
  logic [CORE_W-1:0] owner;
  logic              cap;
  logic              vld_p0;
  logic [CORE_W-1:0] core_p0;
  logic              eve_p0;
  logic              pol_p0;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic              full;
  logic              pop;
  logic              wr_ok;
  logic [CORE_W-1:0] mem_core [DEPTH];
  logic              mem_eve  [DEPTH];
  logic              mem_pol  [DEPTH];
`ifdef RO_TIMESTAMP_EN
  logic [CNT_W-1:0]  ts_p0;
  logic [CNT_W-1:0]  mem_ts   [DEPTH];
`endif

  assign owner    = owner_of(cnt);
  assign cap      = en && (owner != '0) && (bus_eve || bus_pol_eve);
  assign full     = (level == LW'(DEPTH));
  assign rd_valid = (level != '0);
  assign pop      = rd_valid && rd_ready;
  assign wr_ok    = vld_p0 && (!full || pop);

  // Stage p0: sample captured at the end of the owner slot; pushed on the following edge.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt      <= '0;
      vld_p0   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      cnt    <= cnt + CNT_W'(1);
      vld_p0 <= cap;
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (vld_p0 && !wr_ok) begin
        ovf      <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  always_ff @(posedge clk_master) begin
    core_p0 <= owner;
    eve_p0  <= bus_eve;
    pol_p0  <= bus_pol_eve;
`ifdef RO_TIMESTAMP_EN
    ts_p0   <= cnt;
`endif
    if (wr_ok) begin
      mem_core[wr_ptr] <= core_p0;
      mem_eve[wr_ptr]  <= eve_p0;
      mem_pol[wr_ptr]  <= pol_p0;
`ifdef RO_TIMESTAMP_EN
      mem_ts[wr_ptr]   <= ts_p0;
`endif
    end
  end

  // Head fields are forced to zero while the queue is empty.
  assign rd_core    = rd_valid ? mem_core[rd_ptr] : '0;
  assign rd_eve     = rd_valid ? mem_eve[rd_ptr]  : 1'b0;
  assign rd_pol     = rd_valid ? mem_pol[rd_ptr]  : 1'b0;
  assign fifo_level = level;
`ifdef RO_TIMESTAMP_EN
  assign rd_ts      = rd_valid ? mem_ts[rd_ptr]   : '0;
`endif

endmodule
